// File: rtl/cp0_reg.sv
// MIPS Coprocessor-0 register file for the memory stage.
// Holds BadVAddr/Count/Compare/Status/Cause/EPC/PRId, services mtc0/mfc0,
// runs the Count/Compare timer and commits exception/eret side effects.
module cp0_reg #(
  parameter int          TICK_DIV = 2,
  parameter logic [31:0] PRID_VAL = 32'h0000_4220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [31:0] except_type_i,
  input  logic [31:0] pcM_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] badvaddr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic        timer_int_o
);

  // Register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // Status: BEV hard-wired to 1; only IM, EXL and IE are software visible
  localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  // Prescaler width; at least one bit so TICK_DIV==1 still elaborates
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [31:0]   badvaddr_q, badvaddr_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic [31:0]   status_q, status_d;
  logic [31:0]   cause_q, cause_d;
  logic [31:0]   epc_q, epc_d;

  logic        exc_commit;
  logic        eret;
  logic        mtc0_ok;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        tick_wrap;
  logic [31:0] count_inc;
  logic        timer_hit;
  logic        exl;

  // Decode the exception class and qualify the mtc0 write; a flushed
  // instruction's mtc0 is dropped whenever an exception or eret commits.
  always_comb begin
    exc_commit = (except_type_i != EXC_NONE) && (except_type_i != EXC_ERET);
    eret       = (except_type_i == EXC_ERET);
    mtc0_ok    = we_i && !exc_commit && !eret;
    wr_count   = mtc0_ok && (waddr_i == REG_COUNT);
    wr_compare = mtc0_ok && (waddr_i == REG_COMPARE);
    wr_status  = mtc0_ok && (waddr_i == REG_STATUS);
    wr_cause   = mtc0_ok && (waddr_i == REG_CAUSE);
    wr_epc     = mtc0_ok && (waddr_i == REG_EPC);
    exl        = status_q[1];
  end

  // Prescaler and Count; an mtc0 Count write replaces the increment but the
  // prescaler keeps running so the tick phase is not disturbed.
  always_comb begin
    tick_wrap = (tick_q == TICK_LAST);
    tick_d    = tick_wrap ? '0 : tick_q + TW'(1);
    count_inc = count_q + 32'd1;
    count_d   = count_q;
    if (wr_count) begin
      count_d = wdata_i;
    end else if (tick_wrap) begin
      count_d = count_inc;
    end
    // Timer fires only on a real increment landing on Compare
    timer_hit = tick_wrap && !wr_count && (count_inc == compare_q);
    compare_d = wr_compare ? wdata_i : compare_q;
  end

  // Status next state: mtc0 through the write mask, EXL forced by commit/eret
  always_comb begin
    status_d = status_q;
    if (wr_status) begin
      status_d = STATUS_BEV | (wdata_i & STATUS_WMASK);
    end
    if (exc_commit) begin
      status_d[1] = 1'b1;
    end else if (eret) begin
      status_d[1] = 1'b0;
    end
  end

  // Cause next state: software IP, timer flag, hardware IP sampling and
  // exception fields (BD only recorded for the outermost exception).
  always_comb begin
    cause_d = cause_q;
    if (wr_cause) begin
      cause_d[9:8] = wdata_i[9:8];
    end
    // A Compare write acknowledges the timer and wins over a new hit
    if (wr_compare) begin
      cause_d[30] = 1'b0;
    end else if (timer_hit) begin
      cause_d[30] = 1'b1;
    end
    cause_d[15:10] = {ext_int[5] | cause_q[30], ext_int[4:0]};
    if (exc_commit) begin
      if (!exl) begin
        cause_d[31] = is_in_delayslot_i;
      end
      cause_d[6:2] = (except_type_i == EXC_INT) ? 5'd0 : except_type_i[4:0];
    end
  end

  // EPC and BadVAddr next state; exception capture beats an mtc0 EPC write
  always_comb begin
    epc_d = epc_q;
    if (wr_epc) begin
      epc_d = wdata_i;
    end
    if (exc_commit && !exl) begin
      epc_d = is_in_delayslot_i ? (pcM_i - 32'd4) : pcM_i;
    end
    badvaddr_d = badvaddr_q;
    if (exc_commit && ((except_type_i == EXC_ADEL) || (except_type_i == EXC_ADES))) begin
      badvaddr_d = badvaddr_i;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q     <= '0;
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_BEV;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
    end else begin
      tick_q     <= tick_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
    end
  end

  // mfc0 read port: current register values, no bypass of a pending write
  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_q;
      REG_COUNT:    rdata_o = count_q;
      REG_COMPARE:  rdata_o = compare_q;
      REG_STATUS:   rdata_o = status_q;
      REG_CAUSE:    rdata_o = cause_q;
      REG_EPC:      rdata_o = epc_q;
      REG_PRID:     rdata_o = PRID_VAL;
      default:      rdata_o = 32'd0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign count_o     = count_q;
  assign timer_int_o = cause_q[30];

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: reset, timer, write masks, exceptions, eret.
module tb_cp0_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  ext_int;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [31:0] except_type_i;
  logic [31:0] pcM_i;
  logic        is_in_delayslot_i;
  logic [31:0] badvaddr_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] count_o;
  logic        timer_int_o;

  int chk_cnt;
  int pass_cnt;

  cp0_reg #(.TICK_DIV(2), .PRID_VAL(32'h0000_4220)) dut (
    .clk               (clk),
    .rst               (rst),
    .ext_int           (ext_int),
    .we_i              (we_i),
    .waddr_i           (waddr_i),
    .wdata_i           (wdata_i),
    .raddr_i           (raddr_i),
    .rdata_o           (rdata_o),
    .except_type_i     (except_type_i),
    .pcM_i             (pcM_i),
    .is_in_delayslot_i (is_in_delayslot_i),
    .badvaddr_i        (badvaddr_i),
    .status_o          (status_o),
    .cause_o           (cause_o),
    .epc_o             (epc_o),
    .count_o           (count_o),
    .timer_int_o       (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs === exp) begin
      pass_cnt = pass_cnt + 1;
      $display("check %s: got %h", tag, obs);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    we_i              = 1'b0;
    except_type_i     = 32'd0;
    is_in_delayslot_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    rst = 1'b0;
    ext_int = 6'd0;
    we_i = 1'b0;
    waddr_i = 5'd0;
    wdata_i = 32'd0;
    raddr_i = 5'd15;
    except_type_i = 32'd0;
    pcM_i = 32'd0;
    is_in_delayslot_i = 1'b0;
    badvaddr_i = 32'd0;

    // Reset
    step();
    step();
    check_val("rst_status", status_o, 32'h0040_0000);
    check_val("rst_cause", cause_o, 32'd0);
    check_val("rst_epc", epc_o, 32'd0);
    check_val("rst_count", count_o, 32'd0);
    check_val("rst_timer", {31'd0, timer_int_o}, 32'd0);
    check_val("rst_prid", rdata_o, 32'h0000_4220);

    // Compare=5 written on the first edge out of reset (E1)
    rst = 1'b1;
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd5; raddr_i = 5'd11;
    step();
    we_i = 1'b0;
    check_val("compare_rd", rdata_o, 32'd5);
    repeat (8) step();                       // E2..E9
    check_val("count_e9", count_o, 32'd4);
    check_val("timer_e9", {31'd0, timer_int_o}, 32'd0);
    step();                                  // E10
    check_val("count_e10", count_o, 32'd5);
    check_val("timer_e10", {31'd0, timer_int_o}, 32'd1);
    check_val("ip7_e10", {31'd0, cause_o[15]}, 32'd0);
    step();                                  // E11
    check_val("ip7_e11", {31'd0, cause_o[15]}, 32'd1);
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd5;
    step();                                  // E12: ack timer
    check_val("timer_ack", {31'd0, timer_int_o}, 32'd0);
    check_val("count_e12", count_o, 32'd6);
    wdata_i = 32'd7;
    step();                                  // E13: Compare=7
    check_val("ip7_e13", {31'd0, cause_o[15]}, 32'd0);
    step();                                  // E14: hit 7 and Compare write together
    we_i = 1'b0;
    check_val("count_e14", count_o, 32'd7);
    check_val("timer_clr_prio", {31'd0, timer_int_o}, 32'd0);

    // Status write mask and no read bypass
    raddr_i = 5'd12;
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF;
    #1;
    check_val("status_no_bypass", rdata_o, 32'h0040_0000);
    step();
    check_val("status_mask", status_o, 32'h0040_FF03);
    check_val("status_rd", rdata_o, 32'h0040_FF03);
    waddr_i = 5'd13;
    step();
    check_val("cause_mask", cause_o, 32'h0000_0300);
    waddr_i = 5'd12; wdata_i = 32'd0;
    step();
    waddr_i = 5'd13;
    step();
    check_val("status_clear", status_o, 32'h0040_0000);
    check_val("cause_clear", cause_o, 32'd0);

    // Unmapped register reads 0 and ignores writes
    raddr_i = 5'd3; waddr_i = 5'd3; wdata_i = 32'hDEAD_BEEF;
    step();
    we_i = 1'b0;
    check_val("unmapped_rd", rdata_o, 32'd0);

    // Hardware interrupt lines sampled into IP[15:10]
    ext_int = 6'b100001;
    step();
    check_val("hw_ip", {16'd0, cause_o[15:0]} & 32'h0000_FC00, 32'h0000_8400);
    ext_int = 6'd0;
    step();

    // Syscall in a delay slot
    except_type_i = 32'h08; pcM_i = 32'hBFC0_0104; is_in_delayslot_i = 1'b1;
    step();
    clear_ops();
    check_val("sys_epc", epc_o, 32'hBFC0_0100);
    check_val("sys_bd", {31'd0, cause_o[31]}, 32'd1);
    check_val("sys_exccode", 32'(cause_o[6:2]), 32'd8);
    check_val("sys_status", status_o, 32'h0040_0002);

    // Nested address error with EXL already set
    except_type_i = 32'h05; pcM_i = 32'h0040_0200; badvaddr_i = 32'h8000_0003;
    raddr_i = 5'd8;
    step();
    clear_ops();
    check_val("nest_epc", epc_o, 32'hBFC0_0100);
    check_val("nest_bd", {31'd0, cause_o[31]}, 32'd1);
    check_val("nest_exccode", 32'(cause_o[6:2]), 32'd5);
    check_val("nest_badvaddr", rdata_o, 32'h8000_0003);

    // eret clears EXL only
    except_type_i = 32'h0E;
    step();
    clear_ops();
    check_val("eret_status", status_o, 32'h0040_0000);
    check_val("eret_epc", epc_o, 32'hBFC0_0100);

    // Exception and mtc0 EPC in the same cycle
    except_type_i = 32'h0C; pcM_i = 32'h0040_0010;
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h0000_1234;
    step();
    clear_ops();
    check_val("simul_epc", epc_o, 32'h0040_0010);
    check_val("simul_exccode", 32'(cause_o[6:2]), 32'h0C);
    check_val("simul_bd", {31'd0, cause_o[31]}, 32'd0);
    except_type_i = 32'h0E;
    step();
    clear_ops();

    // Interrupt commit; concurrent Compare write is discarded
    except_type_i = 32'h01; pcM_i = 32'h0040_0020;
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'h0000_0099;
    raddr_i = 5'd11;
    step();
    clear_ops();
    check_val("int_exccode", 32'(cause_o[6:2]), 32'd0);
    check_val("int_epc", epc_o, 32'h0040_0020);
    check_val("int_compare_kept", rdata_o, 32'd7);
    except_type_i = 32'h0E;
    step();
    clear_ops();

    // Count wrap
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'hFFFF_FFFF;
    step();
    we_i = 1'b0;
    check_val("count_max", count_o, 32'hFFFF_FFFF);
    step();
    step();
    check_val("count_wrap", count_o, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- MIPS Coprocessor-0 register file for the memory stage.
- Consumes the exception classification produced by the M-stage exception unit: except_type, pcM, badvaddrM and the delay-slot flag.
- Services mtc0/mfc0 and runs the Count/Compare timer.
- Feeds current Status/Cause/EPC back to the exception unit for interrupt qualification and eret target selection.

Parameters:
- TICK_DIV, 2, Count increments once every TICK_DIV clock cycles (≥1).
- PRID_VAL, 32'h0000_4220, read-only value returned for PRId (reg 15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- ext_int  in  6  hardware interrupt lines, level-sensitive
- we_i  in  1  mtc0 write enable (M stage)
- waddr_i  in  5  mtc0 register number
- wdata_i  in  32  mtc0 data
- raddr_i  in  5  mfc0 register number
- rdata_o  out  32  mfc0 read data, combinational from current register state
- except_type_i  in  32  exception code from exception unit; 0 = none, 32'h0E = eret
- pcM_i  in  32  PC of faulting M-stage instruction
- is_in_delayslot_i  in  1  faulting instruction is in a branch delay slot
- badvaddr_i  in  32  faulting address
- status_o  out  32  Status register
- cause_o  out  32  Cause register
- epc_o  out  32  EPC register
- count_o  out  32  Count register
- timer_int_o  out  1  Cause.TI (bit 30)

Behaviour:
- Reset (rst==0 at posedge): BadVAddr=0, Count=0, Compare=0, Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, tick counter=0. Outputs reflect these values the cycle after reset.
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId. Any other address reads 0; writes to it are ignored.
- rdata_o is combinational and returns the pre-write value; no write bypass. The pipeline handles the hazard.
- Write masks:
  - Status: only IM[15:8], EXL[1], IE[0] writable; BEV[22]=1 constant; all other bits 0.
  - Cause: only IP[9:8] writable.
  - EPC, Compare, Count: fully writable.
  - BadVAddr, PRId: read-only.
- Tick: the internal counter counts 0..TICK_DIV-1. Count+1 (mod 2^32, wraps) when the counter is at TICK_DIV-1. An mtc0 Count write overrides the increment that cycle; the tick counter is unaffected.
- Timer: TI is set when Count is incremented to a value equal to Compare. TI stays set until an mtc0 Compare write. That write clears TI and takes priority over a set in the same cycle.
- Cause.IP[15:10] is registered every cycle as {ext_int[5] | TI, ext_int[4:0]}.
- Exception commit, when except_type_i ∉ {0, 0x0E}:
  - If Status.EXL==0:
    - EPC <= is_in_delayslot_i ? pcM_i-4 : pcM_i.
    - Cause.BD[31] <= is_in_delayslot_i.
  - If Status.EXL==1: EPC and BD are unchanged.
  - Always: Status.EXL <= 1.
  - Cause.ExcCode[6:2] <= 0 for type 0x01 (interrupt), otherwise except_type_i[4:0]. Codes: 04,05,08,09,0A,0C.
  - BadVAddr <= badvaddr_i for types 0x04/0x05 only.
- eret (except_type_i==0x0E): Status.EXL <= 0; nothing else changes.
- Priority in one cycle: exception/eret update beats an mtc0 write to the same field. An mtc0 to an unrelated register in the same cycle is discarded, because the faulting instruction is flushed. Timer and IP updates still occur.
- All updates take effect at the next posedge (1-cycle latency); status/cause/epc outputs are registered values.

Test Plan:
- Reset: hold rst=0 two cycles → status_o=32'h0040_0000, cause_o=0, epc_o=0, count_o=0, rdata_o(raddr 15)=32'h0000_4220.
- Count/Compare with TICK_DIV=2:
  - write Compare=5 → count_o reaches 5 after 10 cycles; timer_int_o=1 the same edge; cause_o[15]=1 one cycle later.
  - write Compare=5 again → timer_int_o=0.
- Write masks: mtc0 Status=32'hFFFF_FFFF → status_o=32'h0040_FF03; mtc0 Cause=32'hFFFF_FFFF → cause_o[9:8]=2'b11, all other non-hardware bits 0.
- Syscall in delay slot: except_type=0x08, pcM=32'hBFC0_0104, delayslot=1, EXL=0 → epc_o=32'hBFC0_0100, cause_o[31]=1, ExcCode=8, status_o[1]=1. A following eret → status_o[1]=0.
- Nested exception: with EXL=1, except_type=0x05, badvaddr=32'h8000_0003 → EPC unchanged, BadVAddr=32'h8000_0003, ExcCode=5.
- Simultaneous: except_type=0x0C and mtc0 EPC=32'h1234 same cycle → EPC=pcM_i; interrupt type 0x01 → ExcCode=0; Count wraps 32'hFFFF_FFFF→0.
